// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data memory, branch select and MEM/WB latch.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned loads/stores.
module mem_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  five_bit_muxout,
    output logic        PCSrc,
    output logic [1:0]  mem_wb_ctlout,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg,
    output logic        misalign_err
);

    // Data memory starts out all-zero; reset never clears it.
    logic [31:0]       mem_q [DEPTH] = '{default: 32'h0000_0000};

    logic [ADDR_W-1:0] index_s;
    logic [31:0]       rd_word_s;
    logic              misalign_s;
    logic              wr_en_s;
    logic [31:0]       read_data_d;

    logic [1:0]        ctl_q;
    logic [31:0]       read_data_q;
    logic [31:0]       alu_result_q;
    logic [4:0]        write_reg_q;
    logic              misalign_q;

    assign PCSrc     = branch & zero;
    // Upper address bits are dropped, so accesses wrap modulo DEPTH*4 bytes.
    assign index_s   = alu_result[ADDR_W+1:2];
    assign rd_word_s = mem_q[index_s];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign_s = (memread | memwrite) & (alu_result[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // A store coinciding with reset is dropped, as is a misaligned one.
    assign wr_en_s = memwrite & ~misalign_s & ~rst;

    // Load data for the MEM/WB latch: the word read before any same-edge store.
    always_comb begin
        read_data_d = 32'h0000_0000;
        if (memread && !misalign_s) begin
            read_data_d = rd_word_s;
        end else begin
            read_data_d = 32'h0000_0000;
        end
    end

    // MEM/WB pipeline latch; advances every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_q        <= 2'b00;
            read_data_q  <= 32'h0000_0000;
            alu_result_q <= 32'h0000_0000;
            write_reg_q  <= 5'd0;
            misalign_q   <= 1'b0;
        end else begin
            ctl_q        <= wb_ctl;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result;
            write_reg_q  <= five_bit_muxout;
            misalign_q   <= misalign_s;
        end
    end

    // Store port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[index_s] <= rdata2;
        end
    end

    assign mem_wb_ctlout  = ctl_q;
    assign read_data      = read_data_q;
    assign mem_alu_result = alu_result_q;
    assign mem_write_reg  = write_reg_q;
    assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: random traffic against a behavioural memory model plus directed cases.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_ctl;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  five_bit_muxout;
    logic        PCSrc;
    logic [1:0]  mem_wb_ctlout;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_write_reg;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [256];
    logic        exp_valid = 1'b0;
    logic [1:0]  exp_ctl;
    logic [31:0] exp_rd;
    logic [31:0] exp_alu;
    logic [4:0]  exp_reg;
    logic        exp_mis;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .wb_ctl          (wb_ctl),
        .branch          (branch),
        .memread         (memread),
        .memwrite        (memwrite),
        .zero            (zero),
        .alu_result      (alu_result),
        .rdata2          (rdata2),
        .five_bit_muxout (five_bit_muxout),
        .PCSrc           (PCSrc),
        .mem_wb_ctlout   (mem_wb_ctlout),
        .read_data       (read_data),
        .mem_alu_result  (mem_alu_result),
        .mem_write_reg   (mem_write_reg),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_misaligned(input logic rd, input logic wr, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (rd || wr) && (a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference behaviour at a rising edge, from the inputs present at that edge.
    task automatic model_edge();
        int idx;
        bit mis;
        if (rst) begin
            exp_ctl = 2'b00; exp_rd = 32'h0; exp_alu = 32'h0; exp_reg = 5'd0; exp_mis = 1'b0;
        end else begin
            idx = int'((alu_result / 4) % 256);
            mis = is_misaligned(memread, memwrite, alu_result);
            exp_rd  = (memread && !mis) ? model_mem[idx] : 32'h0;
            if (memwrite && !mis) model_mem[idx] = rdata2;
            exp_ctl = wb_ctl;
            exp_alu = alu_result;
            exp_reg = five_bit_muxout;
            exp_mis = mis;
        end
        exp_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        wb_ctl = 2'b00; branch = 1'b0; zero = 1'b0; memread = 1'b0; memwrite = 1'b0;
        alu_result = 32'h0; rdata2 = 32'h0; five_bit_muxout = 5'd0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        set_idle();
        memread = rd; memwrite = wr; alu_result = a; rdata2 = d;
    endtask

    task automatic randomize_inputs();
        wb_ctl = 2'($urandom); branch = 1'($urandom); zero = 1'($urandom);
        memread = 1'($urandom); memwrite = 1'($urandom);
        alu_result = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
        rdata2 = $urandom; five_bit_muxout = 5'($urandom);
    endtask

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("pcsrc", {31'h0, PCSrc}, {31'h0, branch & zero});
            check("wb_ctl", {30'h0, mem_wb_ctlout}, {30'h0, exp_ctl});
            check("read_data", read_data, exp_rd);
            check("alu_result", mem_alu_result, exp_alu);
            check("write_reg", {27'h0, mem_write_reg}, {27'h0, exp_reg});
            check("misalign", {31'h0, misalign_err}, {31'h0, exp_mis});
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        rst = 1'b1;
        randomize_inputs();
        #2;
        check("reset_rd", read_data, 32'h0);
        check("reset_ctl", {30'h0, mem_wb_ctlout}, 32'h0);
        check("reset_alu", mem_alu_result, 32'h0);
        check("reset_reg", {27'h0, mem_write_reg}, 32'h0);
        check("reset_mis", {31'h0, misalign_err}, 32'h0);
        exp_ctl = 2'b00; exp_rd = 32'h0; exp_alu = 32'h0; exp_reg = 5'd0; exp_mis = 1'b0;
        exp_valid = 1'b1;
        tick();
        rst = 1'b0;
        set_idle();
        tick();

        // Store then load at 0x10.
        set_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF); tick();
        set_op(1'b1, 1'b0, 32'h10, 32'h0);        tick();
        check("sw_lw", read_data, 32'hDEADBEEF);

        // Simultaneous read and write returns the old word.
        set_op(1'b0, 1'b1, 32'h20, 32'h1); tick();
        set_op(1'b1, 1'b1, 32'h20, 32'h2); tick();
        check("rbw_old", read_data, 32'h1);
        set_op(1'b1, 1'b0, 32'h20, 32'h0); tick();
        check("rbw_new", read_data, 32'h2);

        // Address wrap-around.
        set_op(1'b0, 1'b1, 32'h0000_0400, 32'hA5); tick();
        set_op(1'b1, 1'b0, 32'h0, 32'h0);          tick();
        check("wrap", read_data, 32'hA5);

        // Branch select.
        set_idle(); branch = 1'b1; zero = 1'b1; wb_ctl = 2'b10; #1;
        check("pcsrc_taken", {31'h0, PCSrc}, 32'h1);
        tick();
        check("ctl_taken", {30'h0, mem_wb_ctlout}, 32'h2);
        set_idle(); branch = 1'b1; zero = 1'b0; wb_ctl = 2'b10; #1;
        check("pcsrc_not", {31'h0, PCSrc}, 32'h0);
        tick();
        check("ctl_not", {30'h0, mem_wb_ctlout}, 32'h2);

        // Misaligned store to word 4.
        set_op(1'b0, 1'b1, 32'h13, 32'hFF); tick();
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_flag", {31'h0, misalign_err}, 32'h1);
`else
        check("mis_flag", {31'h0, misalign_err}, 32'h0);
`endif
        set_op(1'b1, 1'b0, 32'h10, 32'h0); tick();
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_word4", read_data, 32'hDEADBEEF);
`else
        check("mis_word4", read_data, 32'hFF);
`endif

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            tick();
        end

        // Reset asserted mid-cycle, store attempted during reset.
        set_op(1'b0, 1'b1, 32'h0, 32'h0);
        randomize_inputs();
        #2;
        rst = 1'b1;
        exp_ctl = 2'b00; exp_rd = 32'h0; exp_alu = 32'h0; exp_reg = 5'd0; exp_mis = 1'b0;
        #1;
        check("midrst_rd", read_data, 32'h0);
        check("midrst_alu", mem_alu_result, 32'h0);
        memwrite = 1'b1; memread = 1'b0; alu_result = 32'h30; rdata2 = 32'h1234_5678;
        tick();
        rst = 1'b0;
        set_op(1'b1, 1'b0, 32'h30, 32'h0);
        #1;
        check("hold_after_rst", read_data, 32'h0);
        tick();
        for (int n = 0; n < 100; n++) begin
            randomize_inputs();
            tick();
        end
        set_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
